// File: rtl/seq_pkg.sv
// Shared definitions for the 24-bit-instruction sequencer.
// Optional feature macro: SEQ_STEP_EN (adds the single-step PAUSE state).
package seq_pkg;

    // Instruction word layout
    localparam int IR_W    = 24;
    localparam int IMM_MSB = 23;
    localparam int IMM_LSB = 8;
    localparam int BSEL    = 7;
    localparam int RA_MSB  = 6;
    localparam int RA_LSB  = 5;
    localparam int RB_MSB  = 4;
    localparam int RB_LSB  = 3;
    localparam int OP      = 2;
    localparam int WA_MSB  = 1;
    localparam int WA_LSB  = 0;

    // ALU operation select
    localparam logic ALU_PASS = 1'b0;
    localparam logic ALU_ADD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
`ifdef SEQ_STEP_EN
        ST_DONE  = 3'd4,
        ST_PAUSE = 3'd5
`else
        ST_DONE  = 3'd4
`endif
    } seq_state_e;

    // True while an instruction sequence is in progress.
    function automatic logic state_is_busy(input seq_state_e st);
        logic b;
        b = (st == ST_FETCH) || (st == ST_EXEC) || (st == ST_WB);
`ifdef SEQ_STEP_EN
        b = b || (st == ST_PAUSE);
`endif
        return b;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational split of the latched instruction word into register-file
// and ALU control fields.
module seq_decode
    import seq_pkg::*;
(
    input  logic [IR_W-1:0]          ir,
    output logic [1:0]               rf_ra,
    output logic [1:0]               rf_rb,
    output logic [1:0]               rf_wa,
    output logic                     alu_op,
    output logic                     alu_bsel,
    output logic [IMM_MSB-IMM_LSB:0] alu_imm
);

    // Pure field extraction; IR is stable for a whole instruction so these never glitch.
    always_comb begin
        rf_ra    = ir[RA_MSB:RA_LSB];
        rf_rb    = ir[RB_MSB:RB_LSB];
        rf_wa    = ir[WA_MSB:WA_LSB];
        alu_op   = ir[OP];
        alu_bsel = ir[BSEL];
        alu_imm  = ir[IMM_MSB:IMM_LSB];
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer: owns the PC, latches instructions and strobes the
// register-file write. Runs addresses 0..LAST_ADDR on a start pulse.
// Optional feature macro: SEQ_STEP_EN (adds input step and a PAUSE state
// between instructions).
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | imem_addr = pc, IR loads imem_d at end of cycle
// EXEC  | decode fields stable, external ALU settles
// WB    | rf_we high, pc advances, last address ends the run
// DONE  | run complete, waiting for start to rerun
// PAUSE | (SEQ_STEP_EN) waiting for step before next FETCH
module seq_ctrl
    import seq_pkg::*;
#(
    parameter logic [7:0] LAST_ADDR = 8'h16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef SEQ_STEP_EN
    input  logic        step,
`endif
    output logic [7:0]  imem_addr,
    input  logic [23:0] imem_d,
    output logic [1:0]  rf_ra,
    output logic [1:0]  rf_rb,
    output logic [1:0]  rf_wa,
    output logic        rf_we,
    output logic        alu_op,
    output logic        alu_bsel,
    output logic [15:0] alu_imm,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pc
);

    seq_state_e      state_q, state_d;
    logic [7:0]      pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            rf_we_q, rf_we_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state, PC and IR update; status flags are derived from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = 8'd0;
                end
            end
            ST_FETCH: begin
                ir_d    = imem_d;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                pc_d = pc_q + 8'd1;
                if (pc_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
`ifdef SEQ_STEP_EN
                    state_d = ST_PAUSE;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef SEQ_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rf_we_d = (state_d == ST_WB);
        busy_d  = state_is_busy(state_d);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'd0;
            ir_q    <= '0;
            rf_we_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rf_we_q <= rf_we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    seq_decode u_decode (
        .ir       (ir_q),
        .rf_ra    (rf_ra),
        .rf_rb    (rf_rb),
        .rf_wa    (rf_wa),
        .alu_op   (alu_op),
        .alu_bsel (alu_bsel),
        .alu_imm  (alu_imm)
    );

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign rf_we     = rf_we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
